// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage unit (master) and the data memory (slave).
// A request is held with stable fields until the memory acks it.
interface mem_access_unit_if #(
    parameter int NB_REG    = 32,
    parameter int NB_ADDR_W = 11
) ();
    logic                   req;
    logic                   we;
    logic [NB_ADDR_W-1:0]   addr;
    logic [NB_REG/8-1:0]    be;
    logic [NB_REG-1:0]      wdata;
    logic                   ack;
    logic [NB_REG-1:0]      rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS MEM-stage unit: issues loads/stores over a req/ack data-memory bus,
// stalls upstream while an access is outstanding, and fills the MEM/WB register.
module mem_access_unit #(
    parameter int NB_REG    = 32,
    parameter int NB_WB     = 8,
    parameter int NB_ADDR_W = 11,
    parameter int TIMEOUT   = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [4:0]          i_mem,
    input  logic [NB_REG-1:0]   i_alu_o,
    input  logic [NB_REG-1:0]   i_b_o,
    input  logic [NB_WB-1:0]    i_wb,
    input  logic [NB_REG-1:0]   i_pc,
    output logic                o_stall,
    output logic                o_valid,
    output logic [NB_REG-1:0]   o_reg_wb,
    output logic [NB_REG-1:0]   o_ext_mem_o,
    output logic [NB_WB-1:0]    o_wb,
    output logic [NB_REG-1:0]   o_pc,
    output logic                o_exc_misaligned,
    output logic                o_exc_bus_err,
    mem_access_unit_if.master   dmem
);
    localparam int NBE    = NB_REG / 8;
    localparam int LB     = $clog2(NBE);
    localparam int NB_CNT = $clog2(TIMEOUT) + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state_q, state_d;
    logic [NB_CNT-1:0]    cnt_q, cnt_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [NB_ADDR_W-1:0] addr_q, addr_d;
    logic [NBE-1:0]       be_q, be_d;
    logic [NB_REG-1:0]    wdata_q, wdata_d;
    logic [LB-1:0]        off_q, off_d;
    logic [1:0]           size_q, size_d;
    logic                 su_q, su_d;
    logic                 valid_q, valid_d;
    logic [NB_REG-1:0]    reg_wb_q, reg_wb_d;
    logic [NB_REG-1:0]    ext_q, ext_d;
    logic [NB_WB-1:0]     wb_q, wb_d;
    logic [NB_REG-1:0]    pc_q, pc_d;
    logic                 exc_mis_q, exc_mis_d;
    logic                 exc_bus_q, exc_bus_d;

    logic                 re, we, s_u;
    logic [1:0]           size_eff;
    logic [LB-1:0]        off;
    logic                 mem_op, misaligned, timeout;
    logic [NBE-1:0]       be_mask;
    logic [NB_REG-1:0]    wdata_st, rd_shift, load_ext;

    assign re  = i_mem[4];
    assign we  = i_mem[3];
    assign s_u = i_mem[2];
    // A dword request on a 32-bit datapath degrades to a word access.
    assign size_eff = (i_mem[1:0] == 2'b11 && NB_REG == 32) ? 2'b10 : i_mem[1:0];
    assign off      = i_alu_o[LB-1:0];
    assign mem_op   = i_valid & (re | we);
    assign timeout  = (state_q == WAIT) && !dmem.ack && (cnt_q == NB_CNT'(TIMEOUT - 2));

    always_comb begin
        misaligned = 1'b0;
        be_mask    = '1;
        wdata_st   = i_b_o;
        case (size_eff)
            2'd0: begin
                be_mask  = NBE'(1);
                wdata_st = {NBE{i_b_o[7:0]}};
            end
            2'd1: begin
                misaligned = off[0];
                be_mask    = NBE'(3);
                wdata_st   = {(NB_REG/16){i_b_o[15:0]}};
            end
            2'd2: begin
                misaligned = off[1] | off[0];
                be_mask    = NBE'(15);
                wdata_st   = {(NB_REG/32){i_b_o[31:0]}};
            end
            default: misaligned = |off;
        endcase
    end

    always_comb begin
        rd_shift = dmem.rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    load_ext = su_q ? NB_REG'(rd_shift[7:0])  : NB_REG'($signed(rd_shift[7:0]));
            2'd1:    load_ext = su_q ? NB_REG'(rd_shift[15:0]) : NB_REG'($signed(rd_shift[15:0]));
            2'd2:    load_ext = su_q ? NB_REG'(rd_shift[31:0]) : NB_REG'($signed(rd_shift[31:0]));
            default: load_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        off_d     = off_q;
        size_d    = size_q;
        su_d      = su_q;
        valid_d   = 1'b0;
        reg_wb_d  = reg_wb_q;
        ext_d     = ext_q;
        wb_d      = wb_q;
        pc_d      = pc_q;
        exc_mis_d = 1'b0;
        exc_bus_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && misaligned) begin
                    valid_d   = 1'b1;
                    wb_d      = '0;
                    exc_mis_d = 1'b1;
                end else if (mem_op) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = we;
                    addr_d  = i_alu_o[NB_ADDR_W+LB-1:LB];
                    be_d    = we ? (be_mask << off) : '0;
                    wdata_d = we ? wdata_st : '0;
                    off_d   = off;
                    size_d  = size_eff;
                    su_d    = s_u;
                end else if (i_valid) begin
                    valid_d  = 1'b1;
                    reg_wb_d = i_alu_o;
                    wb_d     = i_wb;
                    pc_d     = i_pc;
                    ext_d    = '0;
                end
            end
            WAIT: begin
                if (dmem.ack) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    valid_d  = 1'b1;
                    reg_wb_d = i_alu_o;
                    wb_d     = i_wb;
                    pc_d     = i_pc;
                    ext_d    = we_q ? '0 : load_ext;
                end else if (timeout) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    valid_d   = 1'b1;
                    wb_d      = '0;
                    exc_bus_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + NB_CNT'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            off_q     <= '0;
            size_q    <= '0;
            su_q      <= 1'b0;
            valid_q   <= 1'b0;
            reg_wb_q  <= '0;
            ext_q     <= '0;
            wb_q      <= '0;
            pc_q      <= '0;
            exc_mis_q <= 1'b0;
            exc_bus_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            off_q     <= off_d;
            size_q    <= size_d;
            su_q      <= su_d;
            valid_q   <= valid_d;
            reg_wb_q  <= reg_wb_d;
            ext_q     <= ext_d;
            wb_q      <= wb_d;
            pc_q      <= pc_d;
            exc_mis_q <= exc_mis_d;
            exc_bus_q <= exc_bus_d;
        end
    end

    // Stall is held low during reset so upstream is never frozen by a dying access.
    assign o_stall = !i_reset &&
                     (((state_q == IDLE) && mem_op && !misaligned) ||
                      ((state_q == WAIT) && !dmem.ack && !timeout));

    assign o_valid          = valid_q;
    assign o_reg_wb         = reg_wb_q;
    assign o_ext_mem_o      = ext_q;
    assign o_wb             = wb_q;
    assign o_pc             = pc_q;
    assign o_exc_misaligned = exc_mis_q;
    assign o_exc_bus_err    = exc_bus_q;
    assign dmem.req         = req_q;
    assign dmem.we          = we_q;
    assign dmem.addr        = addr_q;
    assign dmem.be          = be_q;
    assign dmem.wdata       = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit instance for the load/store/exception
// scenarios and a 64-bit instance for dword loads and reset during an access.
module tb_mem_access_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        rst32, v32, stall32, ov32, mis32, berr32;
    logic [4:0]  mem32;
    logic [31:0] alu32, b32, pc32, rwb32, ext32, opc32;
    logic [7:0]  wb32, owb32;

    logic        rst64, v64, stall64, ov64, mis64, berr64;
    logic [4:0]  mem64;
    logic [63:0] alu64, b64, pc64, rwb64, ext64, opc64;
    logic [7:0]  wb64, owb64;

    mem_access_unit_if #(.NB_REG(32), .NB_ADDR_W(11)) bus32 ();
    mem_access_unit_if #(.NB_REG(64), .NB_ADDR_W(11)) bus64 ();

    mem_access_unit #(.NB_REG(32), .NB_WB(8), .NB_ADDR_W(11), .TIMEOUT(16)) u32 (
        .i_clock(clk), .i_reset(rst32), .i_valid(v32), .i_mem(mem32),
        .i_alu_o(alu32), .i_b_o(b32), .i_wb(wb32), .i_pc(pc32),
        .o_stall(stall32), .o_valid(ov32), .o_reg_wb(rwb32), .o_ext_mem_o(ext32),
        .o_wb(owb32), .o_pc(opc32), .o_exc_misaligned(mis32), .o_exc_bus_err(berr32),
        .dmem(bus32)
    );

    mem_access_unit #(.NB_REG(64), .NB_WB(8), .NB_ADDR_W(11), .TIMEOUT(16)) u64 (
        .i_clock(clk), .i_reset(rst64), .i_valid(v64), .i_mem(mem64),
        .i_alu_o(alu64), .i_b_o(b64), .i_wb(wb64), .i_pc(pc64),
        .o_stall(stall64), .o_valid(ov64), .o_reg_wb(rwb64), .o_ext_mem_o(ext64),
        .o_wb(owb64), .o_pc(opc64), .o_exc_misaligned(mis64), .o_exc_bus_err(berr64),
        .dmem(bus64)
    );

    task automatic applyStimulus32(input logic v, input logic [4:0] m, input logic [31:0] a,
                                   input logic [31:0] b, input logic [7:0] w, input logic [31:0] p);
        v32 = v; mem32 = m; alu32 = a; b32 = b; wb32 = w; pc32 = p;
    endtask

    task automatic applyStimulus64(input logic v, input logic [4:0] m, input logic [63:0] a,
                                   input logic [63:0] b, input logic [7:0] w, input logic [63:0] p);
        v64 = v; mem64 = m; alu64 = a; b64 = b; wb64 = w; pc64 = p;
    endtask

    // Starts at a negedge with the op applied; acks in the n_wait-th WAIT cycle.
    task automatic run_access32(input int n_wait, input logic [31:0] rdata, output int stall_cnt,
                                output logic req_s, output logic we_s, output logic [10:0] addr_s,
                                output logic [3:0] be_s, output logic [31:0] wd_s);
        stall_cnt = 0; req_s = 0; we_s = 0; addr_s = 0; be_s = 0; wd_s = 0;
        for (int c = 0; c <= n_wait; c++) begin
            if (c == n_wait) begin bus32.ack = 1'b1; bus32.rdata = rdata; end
            #1;
            if (stall32) stall_cnt++;
            if (c == 1) begin
                req_s = bus32.req; we_s = bus32.we; addr_s = bus32.addr;
                be_s = bus32.be; wd_s = bus32.wdata;
            end
            @(negedge clk);
        end
        bus32.ack = 1'b0;
        v32 = 1'b0;
    endtask

    task automatic run_access64(input int n_wait, input logic [63:0] rdata, output int stall_cnt,
                                output logic req_s, output logic we_s, output logic [10:0] addr_s,
                                output logic [7:0] be_s, output logic [63:0] wd_s);
        stall_cnt = 0; req_s = 0; we_s = 0; addr_s = 0; be_s = 0; wd_s = 0;
        for (int c = 0; c <= n_wait; c++) begin
            if (c == n_wait) begin bus64.ack = 1'b1; bus64.rdata = rdata; end
            #1;
            if (stall64) stall_cnt++;
            if (c == 1) begin
                req_s = bus64.req; we_s = bus64.we; addr_s = bus64.addr;
                be_s = bus64.be; wd_s = bus64.wdata;
            end
            @(negedge clk);
        end
        bus64.ack = 1'b0;
        v64 = 1'b0;
    endtask

    task automatic test_reset;
        rst32 = 1'b1; rst64 = 1'b1;
        applyStimulus32(0, 5'b0, 32'h0, 32'h0, 8'h0, 32'h0);
        applyStimulus64(0, 5'b0, 64'h0, 64'h0, 8'h0, 64'h0);
        bus32.ack = 0; bus32.rdata = 0; bus64.ack = 0; bus64.rdata = 0;
        repeat (3) @(negedge clk);
        checks++; if (ov32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", ov32); end
        checks++; if (stall32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall32); end
        checks++; if (bus32.req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", bus32.req); end
        checks++; if (bus32.be !== 4'h0) begin errors++; $display("[TB] FAIL reset_be: got %h expected 0", bus32.be); end
        checks++; if (rwb32 !== 32'h0) begin errors++; $display("[TB] FAIL reset_reg_wb: got %h expected 0", rwb32); end
        checks++; if ({mis32, berr32} !== 2'b00) begin errors++; $display("[TB] FAIL reset_exc: got %b expected 00", {mis32, berr32}); end
        checks++; if (ext64 !== 64'h0) begin errors++; $display("[TB] FAIL reset_ext64: got %h expected 0", ext64); end
        rst32 = 1'b0; rst64 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw;
        int sc; logic rq, we; logic [10:0] ad; logic [3:0] be; logic [31:0] wd;
        applyStimulus32(1, 5'b10010, 32'h10, 32'h0, 8'hA5, 32'h100);
        run_access32(3, 32'hDEADBEEF, sc, rq, we, ad, be, wd);
        checks++; if (sc !== 3) begin errors++; $display("[TB] FAIL lw_stall_cycles: got %0d expected 3", sc); end
        checks++; if (rq !== 1'b1) begin errors++; $display("[TB] FAIL lw_req: got %b expected 1", rq); end
        checks++; if (ad !== 11'd4) begin errors++; $display("[TB] FAIL lw_addr: got %0d expected 4", ad); end
        checks++; if (be !== 4'b0000) begin errors++; $display("[TB] FAIL lw_be: got %b expected 0000", be); end
        checks++; if (ext32 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw_data: got %h expected deadbeef", ext32); end
        checks++; if (ov32 !== 1'b1) begin errors++; $display("[TB] FAIL lw_valid: got %b expected 1", ov32); end
        checks++; if (owb32 !== 8'hA5 || opc32 !== 32'h100) begin errors++; $display("[TB] FAIL lw_wb_pc: got %h/%h expected a5/100", owb32, opc32); end
        checks++; if (bus32.req !== 1'b0) begin errors++; $display("[TB] FAIL lw_req_drop: got %b expected 0", bus32.req); end
        @(negedge clk);
        checks++; if (ov32 !== 1'b0) begin errors++; $display("[TB] FAIL lw_valid_after: got %b expected 0", ov32); end
    endtask

    task automatic test_passthrough;
        applyStimulus32(1, 5'b00010, 32'h12345678, 32'h0, 8'h3C, 32'h200);
        #1;
        checks++; if (stall32 !== 1'b0) begin errors++; $display("[TB] FAIL pass_stall: got %b expected 0", stall32); end
        @(negedge clk);
        v32 = 1'b0;
        checks++; if (ov32 !== 1'b1) begin errors++; $display("[TB] FAIL pass_valid: got %b expected 1", ov32); end
        checks++; if (rwb32 !== 32'h12345678) begin errors++; $display("[TB] FAIL pass_reg_wb: got %h expected 12345678", rwb32); end
        checks++; if (owb32 !== 8'h3C || opc32 !== 32'h200) begin errors++; $display("[TB] FAIL pass_wb_pc: got %h/%h expected 3c/200", owb32, opc32); end
        checks++; if (ext32 !== 32'h0) begin errors++; $display("[TB] FAIL pass_ext: got %h expected 0", ext32); end
        @(negedge clk);
    endtask

    task automatic test_lb;
        int sc; logic rq, we; logic [10:0] ad; logic [3:0] be; logic [31:0] wd;
        applyStimulus32(1, 5'b10000, 32'h13, 32'h0, 8'h11, 32'h104);
        run_access32(1, 32'h80FF1234, sc, rq, we, ad, be, wd);
        checks++; if (ext32 !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_signed: got %h expected ffffff80", ext32); end
        checks++; if (sc !== 1) begin errors++; $display("[TB] FAIL lb_stall_cycles: got %0d expected 1", sc); end
        applyStimulus32(1, 5'b10100, 32'h13, 32'h0, 8'h11, 32'h108);
        run_access32(1, 32'h80FF1234, sc, rq, we, ad, be, wd);
        checks++; if (ext32 !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu_unsigned: got %h expected 00000080", ext32); end
        applyStimulus32(1, 5'b10001, 32'h12, 32'h0, 8'h11, 32'h10C);
        run_access32(2, 32'h80FF1234, sc, rq, we, ad, be, wd);
        checks++; if (ext32 !== 32'hFFFF80FF) begin errors++; $display("[TB] FAIL lh_signed: got %h expected ffff80ff", ext32); end
    endtask

    task automatic test_sh;
        int sc; logic rq, we; logic [10:0] ad; logic [3:0] be; logic [31:0] wd;
        applyStimulus32(1, 5'b01001, 32'h22, 32'h0000ABCD, 8'h22, 32'h110);
        run_access32(2, 32'h55555555, sc, rq, we, ad, be, wd);
        checks++; if (we !== 1'b1) begin errors++; $display("[TB] FAIL sh_we: got %b expected 1", we); end
        checks++; if (be !== 4'b1100) begin errors++; $display("[TB] FAIL sh_be: got %b expected 1100", be); end
        checks++; if (wd !== 32'hABCDABCD) begin errors++; $display("[TB] FAIL sh_wdata: got %h expected abcdabcd", wd); end
        checks++; if (ad !== 11'd8) begin errors++; $display("[TB] FAIL sh_addr: got %0d expected 8", ad); end
        checks++; if (ext32 !== 32'h0) begin errors++; $display("[TB] FAIL sh_ext: got %h expected 0", ext32); end
        checks++; if (sc !== 2) begin errors++; $display("[TB] FAIL sh_stall_cycles: got %0d expected 2", sc); end
    endtask

    task automatic test_misaligned;
        applyStimulus32(1, 5'b10010, 32'h22, 32'h0, 8'h5A, 32'h400);
        #1;
        checks++; if (stall32 !== 1'b0) begin errors++; $display("[TB] FAIL mis_stall: got %b expected 0", stall32); end
        @(negedge clk);
        checks++; if (mis32 !== 1'b1) begin errors++; $display("[TB] FAIL mis_exc: got %b expected 1", mis32); end
        checks++; if (ov32 !== 1'b1) begin errors++; $display("[TB] FAIL mis_valid: got %b expected 1", ov32); end
        checks++; if (owb32 !== 8'h00) begin errors++; $display("[TB] FAIL mis_wb: got %h expected 00", owb32); end
        checks++; if (bus32.req !== 1'b0) begin errors++; $display("[TB] FAIL mis_req: got %b expected 0", bus32.req); end
        v32 = 1'b0;
        @(negedge clk);
        checks++; if (mis32 !== 1'b0) begin errors++; $display("[TB] FAIL mis_pulse: got %b expected 0", mis32); end
    endtask

    task automatic test_timeout;
        int req_cnt = 0; logic seen = 0; logic ov_s = 0; logic [7:0] wb_s = 8'hXX;
        applyStimulus32(1, 5'b10010, 32'h40, 32'h0, 8'h77, 32'h300);
        bus32.ack = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus32.req) req_cnt++;
            if (berr32) begin seen = 1; ov_s = ov32; wb_s = owb32; v32 = 1'b0; end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL to_bus_err_seen: got %b expected 1", seen); end
        checks++; if (req_cnt !== 15) begin errors++; $display("[TB] FAIL to_req_cycles: got %0d expected 15", req_cnt); end
        checks++; if (ov_s !== 1'b1) begin errors++; $display("[TB] FAIL to_valid: got %b expected 1", ov_s); end
        checks++; if (wb_s !== 8'h00) begin errors++; $display("[TB] FAIL to_wb: got %h expected 00", wb_s); end
        v32 = 1'b0;
        @(negedge clk);
        checks++; if (berr32 !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse: got %b expected 0", berr32); end
        bus32.ack = 1'b1; bus32.rdata = 32'h12345678;
        #1;
        checks++; if (stall32 !== 1'b0) begin errors++; $display("[TB] FAIL late_ack_stall: got %b expected 0", stall32); end
        @(negedge clk);
        bus32.ack = 1'b0;
        checks++; if (ov32 !== 1'b0 || bus32.req !== 1'b0) begin errors++; $display("[TB] FAIL late_ack_valid_req: got %b%b expected 00", ov32, bus32.req); end
        checks++; if (ext32 !== 32'h0) begin errors++; $display("[TB] FAIL late_ack_ext: got %h expected 0", ext32); end
    endtask

    task automatic test_ld64;
        int sc; logic rq, we; logic [10:0] ad; logic [7:0] be; logic [63:0] wd;
        applyStimulus64(1, 5'b10011, 64'h08, 64'h0, 8'h44, 64'h500);
        run_access64(2, 64'h0123456789ABCDEF, sc, rq, we, ad, be, wd);
        checks++; if (ext64 !== 64'h0123456789ABCDEF) begin errors++; $display("[TB] FAIL ld64_data: got %h expected 0123456789abcdef", ext64); end
        checks++; if (ad !== 11'd1 || be !== 8'h00) begin errors++; $display("[TB] FAIL ld64_addr_be: got %0d/%h expected 1/00", ad, be); end
        checks++; if (sc !== 2) begin errors++; $display("[TB] FAIL ld64_stall_cycles: got %0d expected 2", sc); end
    endtask

    task automatic test_reset_mid_wait;
        int bad = 0;
        applyStimulus64(1, 5'b10011, 64'h10, 64'h0, 8'h66, 64'h600);
        bus64.ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus64.req !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_req_before: got %b expected 1", bus64.req); end
        rst64 = 1'b1; v64 = 1'b0;
        @(negedge clk);
        rst64 = 1'b0;
        checks++; if (bus64.req !== 1'b0 || bus64.addr !== 11'd0) begin errors++; $display("[TB] FAIL rst_mid_bus: got %b/%0d expected 0/0", bus64.req, bus64.addr); end
        checks++; if (ext64 !== 64'h0 || ov64 !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_outputs: got %h/%b expected 0/0", ext64, ov64); end
        checks++; if (stall64 !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_stall: got %b expected 0", stall64); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (berr64 || bus64.req || ov64) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL rst_mid_no_exc: got %0d activity cycles expected 0", bad); end
    endtask

    task automatic test_sb64;
        int sc; logic rq, we; logic [10:0] ad; logic [7:0] be; logic [63:0] wd;
        applyStimulus64(1, 5'b01000, 64'h0D, 64'h00000000000000EE, 8'h88, 64'h700);
        run_access64(1, 64'h0, sc, rq, we, ad, be, wd);
        checks++; if (be !== 8'h20) begin errors++; $display("[TB] FAIL sb64_be: got %h expected 20", be); end
        checks++; if (wd !== 64'hEEEEEEEEEEEEEEEE) begin errors++; $display("[TB] FAIL sb64_wdata: got %h expected eeeeeeeeeeeeeeee", wd); end
        checks++; if (ad !== 11'd1 || we !== 1'b1) begin errors++; $display("[TB] FAIL sb64_addr_we: got %0d/%b expected 1/1", ad, we); end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_passthrough;
        test_lb;
        test_sh;
        test_misaligned;
        test_timeout;
        test_ld64;
        test_reset_mid_wait;
        test_sb64;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
